// File: rtl/host_cmd_engine_pkg.sv
// Purpose: shared opcode, status and state encodings for the host command engine.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package host_cmd_engine_pkg;

    // Command opcodes; 5-7 are treated as NOP.
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_WAIT  = 3'd3;
    localparam logic [2:0] OP_POLL  = 3'd4;

    // Response status codes.
    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_TIMEOUT = 2'd1;
    localparam logic [1:0] RSP_BADADDR = 2'd2;
    localparam logic [1:0] RSP_ABORTED = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_POLL  = 3'd4,
        S_RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/host_cmd_engine.sv
// Purpose: executes WRITE/READ/WAIT/POLL host commands against the core register bus.
// Latency: WRITE strobe at k+1; READ/BADADDR response valid at k+2; POLL response one cycle after the final sample.
// Backpressure: one command in flight (cmd_ready_o only in IDLE); a response is held until rsp_ready_i.
// Ports: clk_i/rst_ni clock and async active-low reset; cmd_* command stream in; rsp_* response
//        stream out; abort_i cancels WAIT/POLL; busy_o = not IDLE; reg_in_o/reg_wr_o/reg_out_i
//        register bus (two-lane write data, per-byte strobes, flat read-back).
module host_cmd_engine
    import host_cmd_engine_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_REGS     = 64,
    parameter int ADDR_W       = 16,
    parameter int CNT_W        = 16,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [2:0]                   cmd_op_i,
    input  logic [ADDR_W-1:0]            cmd_addr_i,
    input  logic [DATA_W-1:0]            cmd_data_i,
    input  logic [DATA_W-1:0]            cmd_mask_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic [1:0]                   rsp_status_o,
    input  logic                         abort_i,
    output logic                         busy_o,
    output logic [2*DATA_W-1:0]          reg_in_o,
    output logic [NUM_REGS*DATA_W/8-1:0] reg_wr_o,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_out_i
);

    localparam int BE      = DATA_W / 8;
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    state_e                       state_q;
    logic                         ready_q, busy_q, rsp_valid_q;
    logic [DATA_W-1:0]            rsp_data_q;
    logic [1:0]                   rsp_status_q;
    logic [2*DATA_W-1:0]          reg_in_q;
    logic [NUM_REGS*BE-1:0]       reg_wr_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         addr_ok_q;
    logic [DATA_W-1:0]            data_q, mask_q;
    logic [CNT_W-1:0]             cnt_q;

    // Decode of the command currently offered.
    logic                         cmd_addr_ok;
    logic [IDX_W-1:0]             cmd_idx;
    logic [NUM_REGS*BE-1:0]       wr_strb;
    logic [2*DATA_W-1:0]          wr_lanes;
    logic [CNT_W-1:0]             wait_load;
    // Register selected by the latched command, and its POLL match.
    logic [DATA_W-1:0]            reg_sel;
    logic                         poll_hit;

    assign cmd_addr_ok = ({1'b0, cmd_addr_i} < (ADDR_W+1)'(NUM_REGS));
    assign cmd_idx     = cmd_addr_i[IDX_W-1:0];
    assign wr_strb     = {{(NUM_REGS*BE-BE){1'b0}}, {BE{1'b1}}} << (BE * cmd_idx);
    assign wr_lanes    = cmd_addr_i[0] ? {cmd_data_i, {DATA_W{1'b0}}}
                                       : {{DATA_W{1'b0}}, cmd_data_i};
    assign reg_sel     = DATA_W'(reg_out_i >> (DATA_W * idx_q));
    assign poll_hit    = ((reg_sel ^ data_q) & mask_q) == '0;

    // WAIT 0 runs as WAIT 1; counts beyond the counter range saturate.
    always_comb begin
        wait_load = cmd_data_i[CNT_W-1:0];
        if (cmd_data_i == '0) begin
            wait_load = CNT_W'(1);
        end else if (cmd_data_i > DATA_W'(CNT_MAX)) begin
            wait_load = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= RSP_OK;
            reg_in_q     <= '0;
            reg_wr_q     <= '0;
            idx_q        <= '0;
            addr_ok_q    <= 1'b0;
            data_q       <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // ready_q comes up one cycle after reset release.
                    ready_q <= 1'b1;
                    if (cmd_valid_i && ready_q) begin
                        idx_q     <= cmd_idx;
                        addr_ok_q <= cmd_addr_ok;
                        data_q    <= cmd_data_i;
                        mask_q    <= cmd_mask_i;
                        cnt_q     <= '0;
                        if (cmd_op_i inside {OP_WRITE, OP_READ, OP_WAIT, OP_POLL}) begin
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                        case (cmd_op_i)
                            OP_WRITE: begin
                                state_q <= S_WRITE;
                                if (cmd_addr_ok) begin
                                    reg_wr_q <= wr_strb;
                                    reg_in_q <= wr_lanes;
                                end
                            end
                            OP_READ: state_q <= S_READ;
                            OP_WAIT: begin
                                state_q <= S_WAIT;
                                cnt_q   <= wait_load;
                            end
                            OP_POLL: state_q <= S_POLL;
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_WRITE: begin
                    reg_wr_q <= '0;
                    reg_in_q <= '0;
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b1;
                    busy_q   <= 1'b0;
                end
                S_READ: begin
                    state_q      <= S_RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_data_q   <= addr_ok_q ? reg_sel : '0;
                    rsp_status_q <= addr_ok_q ? RSP_OK : RSP_BADADDR;
                end
                S_WAIT: begin
                    if (abort_i || cnt_q <= CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_POLL: begin
                    // Priority: bad address, match, abort, timeout.
                    if (!addr_ok_q) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_status_q <= RSP_BADADDR;
                    end else if (poll_hit || abort_i || cnt_q >= CNT_W'(POLL_TIMEOUT - 1)) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= reg_sel;
                        rsp_status_q <= poll_hit ? RSP_OK : (abort_i ? RSP_ABORTED : RSP_TIMEOUT);
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_status_o = rsp_status_q;
    assign reg_in_o     = reg_in_q;
    assign reg_wr_o     = reg_wr_q;

endmodule

// File: tb/tb_host_cmd_engine.sv
// Purpose: directed + randomized checks of host_cmd_engine against a cycle-level reference model.
// Latency: expectations expressed in cycles after the accepting edge k.
// Backpressure: drives rsp_ready low for random hold periods before each response handshake.
module tb_host_cmd_engine;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 64;
    localparam int ADDR_W   = 16;
    localparam int CNT_W    = 16;
    localparam int T_POLL   = 16;
    localparam int BE       = DATA_W / 8;

    localparam logic [2:0] C_NOP = 3'd0, C_WRITE = 3'd1, C_READ = 3'd2, C_WAIT = 3'd3, C_POLL = 3'd4;
    localparam int S_OK = 0, S_TMO = 1, S_BAD = 2, S_ABT = 3;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         cmd_valid, cmd_ready;
    logic [2:0]                   cmd_op;
    logic [ADDR_W-1:0]            cmd_addr;
    logic [DATA_W-1:0]            cmd_data, cmd_mask;
    logic                         rsp_valid, rsp_ready;
    logic [DATA_W-1:0]            rsp_data;
    logic [1:0]                   rsp_status;
    logic                         abort, busy;
    logic [2*DATA_W-1:0]          reg_in;
    logic [NUM_REGS*BE-1:0]       reg_wr;
    logic [NUM_REGS*DATA_W-1:0]   reg_out;

    logic [DATA_W-1:0]            mem [NUM_REGS];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_W +: DATA_W] = mem[i];
    end

    host_cmd_engine #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .CNT_W(CNT_W), .POLL_TIMEOUT(T_POLL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_status_o(rsp_status), .abort_i(abort), .busy_o(busy),
        .reg_in_o(reg_in), .reg_wr_o(reg_wr), .reg_out_i(reg_out)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one command and return just after its accepting edge k (inside cycle k+1).
    task automatic send(input logic [2:0] op, input int addr, input logic [31:0] data,
                        input logic [31:0] mask);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) check("cmd_ready_wait_timeout", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = 16'(addr);
        cmd_data  = data;
        cmd_mask  = mask;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = C_NOP;
    endtask

    // Hold the response for 'hold' extra cycles, then handshake and expect IDLE next cycle.
    task automatic finish_rsp(input logic [31:0] d, input int st, input int hold);
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            abort = 1'b0;
            check("rsp_valid", rsp_valid, 1);
            check("rsp_data", rsp_data, d);
            check("rsp_status", rsp_status, st);
            check("busy_in_resp", busy, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("cmd_ready_after_hs", cmd_ready, 1);
    endtask

    task automatic do_write(input int addr, input logic [31:0] data);
        logic [255:0] nib = 256'hF;
        logic [63:0]  lane = 64'(data);
        logic         ok = (addr < NUM_REGS);
        send(C_WRITE, addr, data, 0);
        @(negedge clk);
        check("wr_strobe_k1", reg_wr, ok ? (nib << (4 * addr)) : 256'd0);
        if (ok) check("wr_lane_k1", reg_in, lane << (32 * (addr % 2)));
        check("wr_busy_k1", busy, 1);
        check("wr_ready_k1", cmd_ready, 0);
        @(negedge clk);
        check("wr_strobe_k2", reg_wr, 0);
        check("wr_lane_k2", reg_in, 0);
        check("wr_ready_k2", cmd_ready, 1);
        check("wr_busy_k2", busy, 0);
    endtask

    task automatic do_read(input int addr, input int hold);
        logic ok = (addr < NUM_REGS);
        send(C_READ, addr, 0, 0);
        @(negedge clk);
        check("rd_valid_k1", rsp_valid, 0);
        finish_rsp(ok ? mem[addr] : 32'd0, ok ? S_OK : S_BAD, hold);
    endtask

    // WAIT n, optionally aborted during busy cycle 'a' (0 = never).
    task automatic do_wait(input int n, input int a);
        int len = (n < 1) ? 1 : n;
        if (a > 0 && a < len) len = a;
        send(C_WAIT, 0, 32'(n), 0);
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            check("wait_busy", busy, 1);
            check("wait_ready", cmd_ready, 0);
            check("wait_rsp", rsp_valid, 0);
            abort = (i == a);
        end
        @(negedge clk);
        abort = 1'b0;
        check("wait_done_busy", busy, 0);
        check("wait_done_ready", cmd_ready, 1);
        check("wait_done_rsp", rsp_valid, 0);
    endtask

    // POLL: register holds oldv until sample r, newv from then on; abort during sample 'a'.
    task automatic do_poll(input int addr, input logic [31:0] pd, input logic [31:0] pm,
                           input logic [31:0] oldv, input logic [31:0] newv,
                           input int r, input int a, input int hold);
        logic        ok = (addr < NUM_REGS);
        int          last = 1;
        int          st = S_BAD;
        logic [31:0] d = 0;
        logic [31:0] v;
        if (ok) begin
            mem[addr] = oldv;
            for (int i = 1; i <= T_POLL; i++) begin
                v = (i >= r) ? newv : oldv;
                last = i;
                d = v;
                if (((v ^ pd) & pm) == 0) begin st = S_OK; break; end
                if (i == a)               begin st = S_ABT; break; end
                st = S_TMO;
            end
        end
        send(C_POLL, addr, pd, pm);
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            check("poll_rsp_early", rsp_valid, 0);
            check("poll_busy", busy, 1);
            if (ok && i == r) mem[addr] = newv;
            abort = (i == a);
        end
        finish_rsp(d, st, hold);
    endtask

    logic [31:0] pd, pm, nv, rnd;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = C_NOP; cmd_addr = '0;
        cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b0; abort = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_reg_in", reg_in, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", rsp_status, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);

        // WRITE: directed then random, including out-of-range addresses.
        do_write(5, 32'hDEADBEEF);
        for (int i = 0; i < 12; i++) do_write($urandom_range(0, 79), $urandom);

        // NOP and reserved opcodes have no effect.
        send(C_NOP, 3, 32'h1, 0);
        @(negedge clk);
        check("nop_busy", busy, 0);
        check("nop_ready", cmd_ready, 1);
        send(3'd6, 4, 32'h5, 0);
        @(negedge clk);
        check("op6_busy", busy, 0);
        check("op6_wr", reg_wr, 0);

        // READ: directed with 3 cycles of backpressure, then random.
        mem[2] = 32'h12345678;
        do_read(2, 3);
        for (int i = 0; i < NUM_REGS; i++) mem[i] = $urandom;
        for (int i = 0; i < 10; i++) do_read($urandom_range(0, 70), $urandom_range(0, 3));

        // WAIT lengths.
        do_wait(0, 0);
        do_wait(4, 0);
        for (int i = 0; i < 4; i++) do_wait($urandom_range(1, 20), 0);

        // POLL: bit0 rises at sample 10; never set -> timeout; mask=0 -> first sample.
        do_poll(7, 32'h1, 32'h1, 32'h0, 32'hA5A50001, 10, 0, 1);
        do_poll(7, 32'h1, 32'h1, 32'h000000F0, 32'h000000F0, 1000, 0, 0);
        do_poll(9, $urandom, 32'h0, 32'h13572468, 32'h13572468, 1000, 0, 0);
        // Abort and match in the same cycle: match wins.
        do_poll(11, 32'h80, 32'h80, 32'h0, 32'h80, 5, 5, 0);
        for (int i = 0; i < 8; i++) begin
            rnd = $urandom;
            pd  = $urandom;
            pm  = (32'h1 << $urandom_range(0, 31)) | ($urandom & $urandom & $urandom);
            nv  = (pd & pm) | (rnd & ~pm);
            do_poll($urandom_range(0, 66), pd, pm, nv ^ pm, nv,
                    $urandom_range(1, 20), $urandom_range(0, 20), $urandom_range(0, 2));
        end

        // Bad addresses.
        do_read(64, 1);
        do_write(70, 32'hCAFEF00D);
        do_poll(65, 32'h1, 32'h1, 32'h0, 32'h1, 1, 0, 0);

        // Abort mid-WAIT, then a normal WRITE.
        do_wait(10, 3);
        do_write(12, 32'h0BADC0DE);

        // Reset mid-POLL drops the command; a following WRITE works.
        mem[7] = '0;
        send(C_POLL, 7, 32'h1, 32'h1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", cmd_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_reg_wr", reg_wr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready", cmd_ready, 1);
        check("after_rst_rsp", rsp_valid, 0);
        do_write(33, 32'h600DF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1);
    end

endmodule
